// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU: single-cycle logic/arithmetic/compare ops and a
// 1-bit-per-cycle iterative shifter behind a Start/Busy/Done handshake.
module alu_multicycle #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [3:0]            i_operation,
    input  logic [DATA_WIDTH-1:0] i_srcA,
    input  logic [DATA_WIDTH-1:0] i_srcB,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_aluResult,
    output logic                  o_zero
);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_EQ   = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLT2 = 4'b1100;

    state_t                  r_state;
    state_t                  w_nextState;
    shift_t                  r_shiftKind;
    shift_t                  w_shiftKind;
    logic [DATA_WIDTH-1:0]   r_shiftReg;
    logic [SHAMT_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_zero;
    logic                    r_done;

    logic [DATA_WIDTH-1:0]   w_aluValue;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [SHAMT_WIDTH-1:0]  w_shamt;
    logic                    w_isShift;
    logic                    w_lessThan;
    logic                    w_startShift;
    logic                    w_startSimple;
    logic                    w_finish;

    assign w_shamt    = i_srcB[SHAMT_WIDTH-1:0];
    assign w_lessThan = $signed(i_srcA) < $signed(i_srcB);

    // Shift ops pass SrcA through here; that value only lands when shamt is 0.
    always_comb begin
        w_aluValue  = '0;
        w_isShift   = 1'b0;
        w_shiftKind = SH_SLL;
        case (i_operation)
            OP_AND:  w_aluValue = i_srcA & i_srcB;
            OP_OR:   w_aluValue = i_srcA | i_srcB;
            OP_ADD:  w_aluValue = i_srcA + i_srcB;
            OP_XOR:  w_aluValue = i_srcA ^ i_srcB;
            OP_SUB,
            OP_EQ:   w_aluValue = i_srcA - i_srcB;
            OP_SLT,
            OP_SLT2: w_aluValue = {{(DATA_WIDTH-1){1'b0}}, w_lessThan};
            OP_SLL: begin
                w_aluValue  = i_srcA;
                w_isShift   = 1'b1;
                w_shiftKind = SH_SLL;
            end
            OP_SRL: begin
                w_aluValue  = i_srcA;
                w_isShift   = 1'b1;
                w_shiftKind = SH_SRL;
            end
            OP_SRA: begin
                w_aluValue  = i_srcA;
                w_isShift   = 1'b1;
                w_shiftKind = SH_SRA;
            end
            default: w_aluValue = '0;
        endcase
    end

    // The MSB never changes during an arithmetic right shift, so it is the captured sign.
    always_comb begin
        w_shifted = r_shiftReg;
        case (r_shiftKind)
            SH_SLL:  w_shifted = {r_shiftReg[DATA_WIDTH-2:0], 1'b0};
            SH_SRL:  w_shifted = {1'b0, r_shiftReg[DATA_WIDTH-1:1]};
            SH_SRA:  w_shifted = {r_shiftReg[DATA_WIDTH-1], r_shiftReg[DATA_WIDTH-1:1]};
            default: w_shifted = r_shiftReg;
        endcase
    end

    assign w_startShift  = (r_state == ST_IDLE) && i_start && w_isShift && (w_shamt != '0);
    assign w_startSimple = (r_state == ST_IDLE) && i_start && !w_startShift;
    assign w_finish      = (r_state == ST_SHIFT) && (r_count == SHAMT_WIDTH'(1));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (w_startShift) w_nextState = ST_SHIFT;
            ST_SHIFT: if (w_finish)     w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_nextState;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shiftReg  <= '0;
            r_shiftKind <= SH_SLL;
            r_count     <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_startSimple) begin
                r_result <= w_aluValue;
                r_zero   <= (w_aluValue == '0);
                r_done   <= 1'b1;
            end else if (w_startShift) begin
                r_shiftReg  <= i_srcA;
                r_shiftKind <= w_shiftKind;
                r_count     <= w_shamt;
            end else if (r_state == ST_SHIFT) begin
                if (w_finish) begin
                    r_result <= w_shifted;
                    r_zero   <= (w_shifted == '0);
                    r_done   <= 1'b1;
                    r_count  <= '0;
                end else begin
                    r_shiftReg <= w_shifted;
                    r_count    <= r_count - SHAMT_WIDTH'(1);
                end
            end
        end
    end

    assign o_busy      = (r_state == ST_SHIFT);
    assign o_done      = r_done;
    assign o_aluResult = r_result;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle with hand-computed expectations.
module tb_alu_multicycle;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  operation;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] aluResult;
    logic        zero;

    int checks;
    int failures;
    int latency;

    alu_multicycle #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_operation (operation),
        .i_srcA      (srcA),
        .i_srcB      (srcB),
        .o_busy      (busy),
        .o_done      (done),
        .o_aluResult (aluResult),
        .o_zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        operation = op;
        srcA      = a;
        srcB      = b;
        start     = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        operation = 4'b0000;
        srcA      = '0;
        srcB      = '0;
        tick();
        tick();
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset result", aluResult, 32'd0);
        checkOutput("reset zero", {31'b0, zero}, 32'd0);
        reset = 1'b0;

        // ADD then back-to-back SUB accepted in the Done cycle
        applyStimulus(4'b0010, 32'd5, 32'd7);
        tick();
        applyStimulus(4'b0110, 32'd3, 32'd3);
        checkOutput("add done", {31'b0, done}, 32'd1);
        checkOutput("add result", aluResult, 32'd12);
        checkOutput("add zero", {31'b0, zero}, 32'd0);
        checkOutput("add busy", {31'b0, busy}, 32'd0);
        tick();
        start = 1'b0;
        checkOutput("sub done", {31'b0, done}, 32'd1);
        checkOutput("sub result", aluResult, 32'd0);
        checkOutput("sub zero", {31'b0, zero}, 32'd1);
        tick();
        checkOutput("done single pulse", {31'b0, done}, 32'd0);

        // AND / OR back to back
        applyStimulus(4'b0000, 32'h0000F0F0, 32'h0000FF00);
        tick();
        applyStimulus(4'b0001, 32'h0000F0F0, 32'h0000FF00);
        checkOutput("and result", aluResult, 32'h0000F000);
        tick();
        start = 1'b0;
        checkOutput("or result", aluResult, 32'h0000FFF0);

        // Signed compare, both encodings, then swapped operands
        applyStimulus(4'b0111, 32'hFFFFFFFF, 32'd1);
        tick();
        applyStimulus(4'b1100, 32'hFFFFFFFF, 32'd1);
        checkOutput("slt result", aluResult, 32'd1);
        tick();
        applyStimulus(4'b0111, 32'd1, 32'hFFFFFFFF);
        checkOutput("slt2 result", aluResult, 32'd1);
        tick();
        start = 1'b0;
        checkOutput("slt swap result", aluResult, 32'd0);
        checkOutput("slt swap zero", {31'b0, zero}, 32'd1);
        tick();

        // SRA by 4 with an ignored ADD request while busy
        applyStimulus(4'b1001, 32'h80000000, 32'd4);
        tick();
        applyStimulus(4'b0010, 32'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("sra busy %0d", i), {31'b0, busy}, 32'd1);
            checkOutput($sformatf("sra nodone %0d", i), {31'b0, done}, 32'd0);
            checkOutput($sformatf("sra held %0d", i), aluResult, 32'd0);
            if (i == 3) start = 1'b0;
            tick();
        end
        checkOutput("sra done", {31'b0, done}, 32'd1);
        checkOutput("sra busy end", {31'b0, busy}, 32'd0);
        checkOutput("sra result", aluResult, 32'hF8000000);
        checkOutput("sra zero", {31'b0, zero}, 32'd0);
        tick();
        checkOutput("sra after done", {31'b0, done}, 32'd0);
        checkOutput("sra result kept", aluResult, 32'hF8000000);

        // SLL by 0 completes in one cycle
        applyStimulus(4'b0100, 32'd1, 32'd0);
        tick();
        start = 1'b0;
        checkOutput("sll0 done", {31'b0, done}, 32'd1);
        checkOutput("sll0 result", aluResult, 32'd1);

        // SRL by 31: maximum latency of 32 cycles
        applyStimulus(4'b0101, 32'h80000000, 32'd31);
        tick();
        start   = 1'b0;
        latency = 1;
        while (!done && latency < 40) begin
            tick();
            latency++;
        end
        checkOutput("srl31 latency", latency, 32'd32);
        checkOutput("srl31 result", aluResult, 32'd1);

        // EQ, XOR, and an undefined opcode
        applyStimulus(4'b1000, 32'h1234, 32'h1234);
        tick();
        applyStimulus(4'b0011, 32'd5, 32'd3);
        checkOutput("eq zero", {31'b0, zero}, 32'd1);
        checkOutput("eq result", aluResult, 32'd0);
        tick();
        applyStimulus(4'b1111, 32'd5, 32'd3);
        checkOutput("xor result", aluResult, 32'd6);
        checkOutput("xor zero", {31'b0, zero}, 32'd0);
        tick();
        checkOutput("undef result", aluResult, 32'd0);
        checkOutput("undef zero", {31'b0, zero}, 32'd1);
        applyStimulus(4'b0010, 32'd2, 32'd2);
        tick();
        start = 1'b0;
        checkOutput("add4 result", aluResult, 32'd4);

        // Reset in the middle of an SLL by 10 aborts it
        applyStimulus(4'b0100, 32'd1, 32'd10);
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort busy", {31'b0, busy}, 32'd0);
        checkOutput("abort done", {31'b0, done}, 32'd0);
        checkOutput("abort result", aluResult, 32'd0);
        checkOutput("abort zero", {31'b0, zero}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput($sformatf("abort no done %0d", i), {31'b0, done}, 32'd0);
        end
        applyStimulus(4'b0010, 32'd1, 32'd1);
        tick();
        start = 1'b0;
        checkOutput("post abort done", {31'b0, done}, 32'd1);
        checkOutput("post abort result", aluResult, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Multi-cycle integer ALU that consumes the 4-bit `Operation` code produced by the ALU controller, together with the two 32-bit source operands, and returns a registered result and zero flag. Logical, arithmetic, compare and equality operations complete in one cycle. Shifts use a 1-bit-per-cycle iterative shifter instead of a barrel shifter. A Start/Busy/Done handshake lets the execute-stage control hold the pipeline while a shift is in progress.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `SHAMT_WIDTH`, 5, shift-amount width; shift amount is `SrcB[SHAMT_WIDTH-1:0]`
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `Start`  in  1  request; sampled only in IDLE
- `Operation`  in  4  operation code from the ALU controller
- `SrcA`  in  DATA_WIDTH  operand A; also the shift source
- `SrcB`  in  DATA_WIDTH  operand B; also the shift amount
- `Busy`  out  1  high while a shift is iterating; Start is ignored
- `Done`  out  1  one-cycle pulse; ALUResult/Zero valid from this cycle
- `ALUResult`  out  DATA_WIDTH  registered result; held until the next completion
- `Zero`  out  1  registered, (ALUResult == 0), updated together with ALUResult

## Operation
- Operation decode (all others yield result 0):
  - 0000 AND
  - 0001 OR
  - 0010 ADD (also used for loads/stores)
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SLT (signed)
  - 1000 EQ: result = SrcA − SrcB, so Zero=1 iff the operands are equal
  - 1001 SRA
  - 1100 SLT (signed, identical to 0111)
- SLT result is {31'b0, signed(SrcA) < signed(SrcB)}.
- ADD/SUB/EQ wrap modulo 2^DATA_WIDTH. No overflow or carry output.
- Operands and opcode are captured at Start. Later changes on the inputs do not affect an operation in flight.
- FSM states:
  - IDLE: Busy=0. On Start:
    - Non-shift op, or shift with shamt=0: register the result and Zero, assert Done next cycle, stay in IDLE.
    - Shift with shamt=n>0: load the internal shift register with SrcA and the counter with n, then go to SHIFT.
  - SHIFT: Busy=1. Each cycle shift by 1 and decrement the counter.
    - SLL fills with 0.
    - SRL fills with 0.
    - SRA fills with the captured SrcA[MSB].
    - On the cycle the counter reaches 1, write the shifted value to ALUResult/Zero, pulse Done, and return to IDLE.
- ALUResult and Zero do not change during SHIFT. The previous result stays visible until completion.
- Reset values: state IDLE, Busy=0, Done=0, ALUResult=0, Zero=0, counter=0.
- Reset mid-shift aborts the operation. No Done is produced and ALUResult returns to 0.

## Timing
- Start sampled high at edge k in IDLE:
  - Non-shift op or shamt=0: Done=1 and the new ALUResult in cycle k+1. Latency 1.
  - Shift with shamt=n: Busy=1 in cycles k+1…k+n, Done=1 and the result in cycle k+n+1. Latency n+1, maximum 32.
- Throughput: the FSM is in IDLE during a Done cycle, so a Start in that cycle is accepted. Back-to-back non-shift ops sustain 1 per cycle.
- Start while Busy=1 is ignored. It is not queued and has no effect on the shift or its result.
- Done is never high for two consecutive cycles unless Start is re-asserted each cycle.
- Busy and Done are never high in the same cycle.
- Reset has priority over Start in the same cycle.

## Test plan
- Reset, then ADD SrcA=5, SrcB=7 → next cycle: Done=1, ALUResult=12, Zero=0, Busy=0. Then SUB 3−3 in the following cycle → ALUResult=0, Zero=1, one cycle later.
- SLT with SrcA=0xFFFFFFFF, SrcB=1 → ALUResult=1. Repeat with Operation=1100 → ALUResult=1. Swap the operands → ALUResult=0, Zero=1.
- SRA with SrcA=0x80000000, SrcB=4 → Busy high 4 cycles, Done in cycle 5, ALUResult=0xF8000000. Re-assert Start with ADD while Busy → ignored, and the result is unchanged.
- SLL with SrcA=0x1, SrcB=0 → 1-cycle latency, ALUResult=0x1. SRL with SrcA=0x80000000, SrcB=31 → Done after 32 cycles, ALUResult=0x1.
- EQ 1000 with SrcA=SrcB=0x1234 → Zero=1. Opcode 1111 → ALUResult=0, Zero=1.
- Start SLL with SrcB=10, assert reset in cycle 3 → no Done, Busy=0, ALUResult=0, Zero=0 the next cycle. A subsequent ADD 1+1 → 2.
